// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator: pixel-tick divider, H/V counters, renderer latency
// matching and a registered, blanked output stage.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int COLOR_W  = 4,
  parameter int COORD_W  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COLOR_W-1:0] objRed,
  input  logic [COLOR_W-1:0] objGreen,
  input  logic [COLOR_W-1:0] objBlue,
  output logic               pTick,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               lineStart,
  output logic               frameStart,
  output logic               videoON,
  output logic               hSync,
  output logic               vSync,
  output logic [COLOR_W-1:0] vgaRed,
  output logic [COLOR_W-1:0] vgaGreen,
  output logic [COLOR_W-1:0] vgaBlue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // pTick is a one-clock strobe; every pixel-rate register below advances only when it is
  // high, so consumers treat it as a valid with no back-pressure (there is no ready).
  logic [DIV_W-1:0] div;
  logic             divRun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div    <= '0;
      divRun <= 1'b0;
    end else begin
      divRun <= 1'b1;
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // divRun keeps the CLK_DIV=1 case quiet until the first edge after reset release.
  assign pTick = divRun && (div == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixelX <= '0;
      pixelY <= '0;
    end else if (pTick) begin
      if (pixelX == X_LAST) begin
        pixelX <= '0;
        pixelY <= (pixelY == Y_LAST) ? '0 : pixelY + 1'b1;
      end else begin
        pixelX <= pixelX + 1'b1;
      end
    end
  end

  assign lineStart  = pTick && (pixelX == '0);
  assign frameStart = lineStart && (pixelY == '0);

  logic actRaw, hsRaw, vsRaw;
  assign actRaw = (pixelX < X_ACT) && (pixelY < Y_ACT);
  assign hsRaw  = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
  assign vsRaw  = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);

  logic actDly, hsDly, vsDly;

  generate
    if (PIPE_LAT == 0) begin : gNoDelay
      assign actDly = actRaw;
      assign hsDly  = hsRaw;
      assign vsDly  = vsRaw;
    end else begin : gDelay
      logic [PIPE_LAT-1:0] actSr, hsSr, vsSr;

      // Each shift keeps the low PIPE_LAT bits of {history, newest}; the MSB is the oldest.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          actSr <= '0;
          hsSr  <= '0;
          vsSr  <= '0;
        end else if (pTick) begin
          actSr <= PIPE_LAT'({actSr, actRaw});
          hsSr  <= PIPE_LAT'({hsSr, hsRaw});
          vsSr  <= PIPE_LAT'({vsSr, vsRaw});
        end
      end

      assign actDly = actSr[PIPE_LAT-1];
      assign hsDly  = hsSr[PIPE_LAT-1];
      assign vsDly  = vsSr[PIPE_LAT-1];
    end
  endgenerate

  // Output register: all pins update on the same tick, and colour is forced to zero
  // outside the active area regardless of what the renderer drives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      videoON  <= 1'b0;
      hSync    <= ~HS_POL;
      vSync    <= ~VS_POL;
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
    end else if (pTick) begin
      videoON  <= actDly;
      hSync    <= hsDly ? HS_POL : ~HS_POL;
      vSync    <= vsDly ? VS_POL : ~VS_POL;
      vgaRed   <= actDly ? objRed   : '0;
      vgaGreen <= actDly ? objGreen : '0;
      vgaBlue  <= actDly ? objBlue  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Scoreboard bench for vga_timing_pipe on a tiny 12x7 raster (H 8/1/2/1, V 4/1/1/1),
// CLK_DIV=2, mixed sync polarity and a two-tick renderer latency.
module tb_vga_timing_pipe;

  localparam int CLK_DIV  = 2;
  localparam int PIPE_LAT = 2;

  logic       clock;
  logic       reset;
  logic [3:0] objRed, objGreen, objBlue;
  logic       pTick;
  logic [3:0] pixelX, pixelY;
  logic       lineStart, frameStart, videoON, hSync, vSync;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(CLK_DIV), .HS_POL(1'b1), .VS_POL(1'b0),
    .PIPE_LAT(PIPE_LAT), .COLOR_W(4), .COORD_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .objRed(objRed), .objGreen(objGreen), .objBlue(objBlue),
    .pTick(pTick), .pixelX(pixelX), .pixelY(pixelY),
    .lineStart(lineStart), .frameStart(frameStart),
    .videoON(videoON), .hSync(hSync), .vSync(vSync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // scoreboard state
  logic [0:0]  tick_q[$];
  logic [9:0]  coord_q[$];
  logic [14:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  // bench-side raster model
  int div_m, mx, my;
  bit started_m, last_tick;
  int hx_q[$];
  int hy_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    div_m     = 0;
    started_m = 1'b0;
    mx        = 0;
    my        = 0;
    hx_q.delete();
    hy_q.delete();
  endtask

  // One negedge worth of stimulus: predict pTick, and on a tick predict coordinates,
  // drive the renderer colour for the coordinate two ticks back, and queue the pins.
  task automatic step();
    bit         t, act, hs, vs, have;
    int         dx, dy;
    logic [3:0] r, g, b;
    t = !reset && started_m && (div_m == CLK_DIV - 1);
    tick_q.push_back(t);
    last_tick = t;
    if (t) begin
      coord_q.push_back({4'(mx), 4'(my), (mx == 0), (mx == 0) && (my == 0)});
      hx_q.push_back(mx);
      hy_q.push_back(my);
      have = 1'b0;
      dx = 0;
      dy = 0;
      if (hx_q.size() > PIPE_LAT) begin
        dx = hx_q.pop_front();
        dy = hy_q.pop_front();
        have = 1'b1;
      end
      if (have) begin
        r   = 4'(dx);
        g   = 4'(dy);
        b   = 4'(dx) ^ 4'h5;
        act = (dx < 8) && (dy < 4);
        hs  = (dx == 9) || (dx == 10);
        vs  = (dy == 5);
      end else begin
        r = 4'hF; g = 4'hF; b = 4'hF;
        act = 1'b0; hs = 1'b0; vs = 1'b0;
      end
      objRed   = r;
      objGreen = g;
      objBlue  = b;
      // hSync active-high, vSync active-low in this configuration
      exp_q.push_back({act, hs, ~vs, act ? r : 4'h0, act ? g : 4'h0, act ? b : 4'h0});
      mx++;
      if (mx == 12) begin
        mx = 0;
        my++;
        if (my == 7) my = 0;
      end
    end
    if (!reset) begin
      started_m = 1'b1;
      div_m = (div_m == CLK_DIV - 1) ? 0 : div_m + 1;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      step();
    end
  endtask

  task automatic finish_tick();
    for (int i = 0; i < 4 && last_tick; i++) run_cycles(1);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pixelX"},     32'(pixelX),     32'h0);
    check({tag, "_pixelY"},     32'(pixelY),     32'h0);
    check({tag, "_pTick"},      32'(pTick),      32'h0);
    check({tag, "_lineStart"},  32'(lineStart),  32'h0);
    check({tag, "_frameStart"}, 32'(frameStart), 32'h0);
    check({tag, "_videoON"},    32'(videoON),    32'h0);
    check({tag, "_hSync"},      32'(hSync),      32'h0);
    check({tag, "_vSync"},      32'(vSync),      32'h1);
    check({tag, "_vga"},        32'({vgaRed, vgaGreen, vgaBlue}), 32'h0);
  endtask

  // monitor: pTick every clock; on a tick, coordinates now and pins just after the edge
  initial begin
    logic [0:0]  e_tick;
    logic [9:0]  e_coord;
    logic [14:0] e_pins;
    forever begin
      @(negedge clock);
      #1;
      if (tick_q.size() == 0) begin
        check("tick_q_underflow", 32'(1), 32'(0));
      end else begin
        e_tick = tick_q.pop_front();
        check("pTick", 32'(pTick), 32'(e_tick));
      end
      if (pTick) begin
        if (coord_q.size() == 0) begin
          check("coord_q_underflow", 32'(1), 32'(0));
        end else begin
          e_coord = coord_q.pop_front();
          check("coord", 32'({pixelX, pixelY, lineStart, frameStart}), 32'(e_coord));
        end
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'(1), 32'(0));
        end else begin
          e_pins = exp_q.pop_front();
          check("pins", 32'({videoON, hSync, vSync, vgaRed, vgaGreen, vgaBlue}), 32'(e_pins));
        end
      end
    end
  end

  // driver / sequence
  initial begin
    reset     = 1'b1;
    objRed    = 4'h0;
    objGreen  = 4'h0;
    objBlue   = 4'h0;
    last_tick = 1'b0;
    model_reset();
    run_cycles(3);
    #1;
    check_reset_state("init");
    release_reset();
    run_cycles(400);
    finish_tick();
    // asynchronous reset between edges, mid-line
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("mid");
    model_reset();
    run_cycles(2);
    release_reset();
    run_cycles(300);
    finish_tick();
    @(posedge clock);
    #2;
    check("tick_q_left",  32'(tick_q.size()),  32'(0));
    check("coord_q_left", 32'(coord_q.size()), 32'(0));
    check("exp_q_left",   32'(exp_q.size()),   32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
